palette_select: RTL and testbench
=================================

PALETTE_SELECT -- requirements
Module: palette_select

Interface
REQ-001 SHALL have parameter NUM_PALETTES, default 3: number of valid palette IDs; legal range 1..256.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 250000: consecutive stable cycles required to accept a button level change; minimum 2.
REQ-003 SHALL have parameter INIT_ID, default 0: color_id value after reset; must be less than NUM_PALETTES.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port btn_next, input, 1 bit: raw asynchronous push-button, high = pressed; advances the palette.
REQ-007 SHALL have port btn_prev, input, 1 bit: raw asynchronous push-button, high = pressed; steps the palette back.
REQ-008 SHALL have port color_id, output, 8 bits: registered palette index for the downstream colour lookup.
REQ-009 SHALL have port changed, output, 1 bit: one-cycle pulse, high in the first cycle a new color_id value is visible.

Function
REQ-010 SHALL pass each button through a 2-flop synchronizer before any other logic uses it.
REQ-011 Per button, SHALL keep a debounced level "stable" and a counter; the counter increments on each edge where synchronized input differs from stable, and clears on any edge where they are equal.
REQ-012 On an edge with a mismatch and counter = DEBOUNCE_CYCLES-1, SHALL toggle stable and clear the counter.
REQ-013 SHALL generate a press pulse only on a stable 0->1 transition; a 1->0 transition SHALL generate nothing.
REQ-014 Press pulse SHALL be derived as stable AND NOT stable_delayed, so it is high for exactly one cycle.
REQ-015 A next press alone SHALL set color_id to color_id+1, wrapping NUM_PALETTES-1 -> 0.
REQ-016 A prev press alone SHALL set color_id to color_id-1, wrapping 0 -> NUM_PALETTES-1.
REQ-017 Simultaneous next and prev presses in the same cycle SHALL leave color_id unchanged and SHALL NOT assert changed.
REQ-018 With NUM_PALETTES = 1, color_id SHALL remain 0 and changed SHALL never assert.
REQ-019 color_id and changed SHALL update on the rising edge after the press pulse.
REQ-020 For a raw input held high from before edge 1, color_id SHALL update on edge DEBOUNCE_CYCLES+3.
REQ-021 A raw pulse or glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL cause no press.
REQ-022 Holding a button SHALL produce exactly one step, with no auto-repeat.
REQ-023 color_id SHALL never hold a value of NUM_PALETTES or greater.

Reset
REQ-024 On rst, color_id SHALL become INIT_ID and changed SHALL become 0.
REQ-025 On rst, synchronizer flops and counters SHALL become 0, and stable and stable_delayed SHALL become 1.
REQ-026 A button held through reset release SHALL NOT produce a press until it is released and pressed again.
REQ-027 Reset asserted mid-debounce SHALL discard the partial count.

Structure
REQ-028 A shared package SHALL hold the 8-bit palette ID typedef and the default NUM_PALETTES constant, so the colour lookup stage and this block share one definition.
REQ-029 Synchronizer, debounce counter and edge detect SHALL be a sub-module btn_debounce (parameter DEBOUNCE_CYCLES; ports clk, rst, btn_raw, press), instantiated once per button.
REQ-030 The counter width SHALL be $clog2(DEBOUNCE_CYCLES).

Verification (DEBOUNCE_CYCLES=4, NUM_PALETTES=3, INIT_ID=0)
REQ-031 Reset then btn_next high, held -> color_id 0->1 on edge 7, changed high for exactly that cycle, no further change while held.
REQ-032 Three separate next presses -> color_id 1, 2, 0 (wrap); one prev press from 0 -> color_id 2.
REQ-033 btn_next high for 3 cycles, then low -> color_id stays 0 and changed stays 0.
REQ-034 Both buttons raised on the same edge and held -> simultaneous presses, color_id unchanged, changed stays 0.
REQ-035 btn_prev held across rst deassertion -> no change; release, then press again -> color_id 0->2.
REQ-036 rst asserted after 2 cycles of a held btn_next, released with btn_next low -> color_id 0, no pulse.

Source files
------------

// File: rtl/palette_select_pkg.sv
// Shared palette ID type, default palette count and the wrapping step helper
// used by palette_select and the downstream colour lookup stage.
package palette_select_pkg;

    typedef logic [7:0] palette_id_t;

    localparam int DEFAULT_NUM_PALETTES = 3;

    // Out-of-range inputs are folded back into range so the result is always legal.
    function automatic palette_id_t step_id(input palette_id_t cur, input palette_id_t last,
                                            input logic up);
        palette_id_t nxt;
        if (up) begin
            nxt = (cur >= last) ? 8'd0 : cur + 8'd1;
        end else begin
            nxt = ((cur == 8'd0) || (cur > last)) ? last : cur - 8'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/palette_select_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and
// rising-edge detect producing a one-cycle press pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic             stable_dly_q, stable_dly_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state: synchronizer shift, counter advance/clear, stable toggle.
    always_comb begin
        sync1_d      = btn_raw;
        sync2_d      = sync1_q;
        stable_dly_d = stable_q;
        stable_d     = stable_q;
        cnt_d        = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = ~stable_q;
                cnt_d    = '0;
            end else begin
                stable_d = stable_q;
                cnt_d    = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Stable levels reset high so a button held through reset cannot fire.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stable_q     <= 1'b1;
            stable_dly_q <= 1'b1;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            cnt_q        <= cnt_d;
        end
    end

    assign press = stable_q & ~stable_dly_q;

endmodule

// File: rtl/palette_select.sv
// Palette selector: debounced next/prev buttons step a wrapping palette index
// and flag each new value with a one-cycle changed pulse.
module palette_select
    import palette_select_pkg::*;
#(
    parameter int NUM_PALETTES    = DEFAULT_NUM_PALETTES,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int INIT_ID         = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_next,
    input  logic       btn_prev,
    output logic [7:0] color_id,
    output logic       changed
);

    localparam palette_id_t LAST_ID  = palette_id_t'(NUM_PALETTES - 1);
    localparam palette_id_t RESET_ID = palette_id_t'(INIT_ID);

    logic        press_next;
    logic        press_prev;
    palette_id_t color_id_q, color_id_d;
    logic        changed_q, changed_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_next),
        .press   (press_next)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_prev),
        .press   (press_prev)
    );

    // Simultaneous presses cancel; changed follows any real value change,
    // which also keeps a single-palette build permanently quiet.
    always_comb begin
        color_id_d = color_id_q;
        case ({press_next, press_prev})
            2'b10:   color_id_d = step_id(color_id_q, LAST_ID, 1'b1);
            2'b01:   color_id_d = step_id(color_id_q, LAST_ID, 1'b0);
            default: color_id_d = color_id_q;
        endcase
        changed_d = (color_id_d != color_id_q);
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            color_id_q <= RESET_ID;
            changed_q  <= 1'b0;
        end else begin
            color_id_q <= color_id_d;
            changed_q  <= changed_d;
        end
    end

    assign color_id = color_id_q;
    assign changed  = changed_q;

endmodule

// File: tb/tb_palette_select.sv
// Directed bench for palette_select: expected palette changes are queued with
// the edge they must appear on and checked by a negedge monitor.
module tb_palette_select;

    localparam int NP  = 3;
    localparam int DBC = 4;

    typedef struct {
        int         cyc;
        logic [7:0] id;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_next = 1'b0;
    logic       btn_prev = 1'b0;
    logic [7:0] color_id;
    logic       changed;

    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    int   model_id = 0;
    exp_t sb[$];

    palette_select #(
        .NUM_PALETTES    (NP),
        .DEBOUNCE_CYCLES (DBC),
        .INIT_ID         (0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_next (btn_next),
        .btn_prev (btn_prev),
        .color_id (color_id),
        .changed  (changed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every changed pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (changed === 1'b1) begin
            if (sb.size() == 0) begin
                compared++;
                assert (changed === 1'b0) else begin
                    mismatched++;
                    $error("FAIL spurious_changed: observed changed=%b id=%0d at edge %0d, expected no pulse",
                           changed, color_id, cyc);
                end
            end else begin
                e = sb.pop_front();
                compared++;
                assert (color_id === e.id) else begin
                    mismatched++;
                    $error("FAIL change_id: observed %0d, expected %0d", color_id, e.id);
                end
                compared++;
                assert (cyc === e.cyc) else begin
                    mismatched++;
                    $error("FAIL change_edge: observed edge %0d, expected edge %0d", cyc, e.cyc);
                end
            end
        end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
            e = sb.pop_front();
            compared++;
            assert (cyc <= e.cyc) else begin
                mismatched++;
                $error("FAIL change_timeout: observed no change by edge %0d, expected id %0d at edge %0d",
                       cyc, e.id, e.cyc);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_state(input string tag, input logic [7:0] exp_id, input logic exp_chg);
        compared++;
        assert (color_id === exp_id) else begin
            mismatched++;
            $error("FAIL %s_id: observed %0d, expected %0d", tag, color_id, exp_id);
        end
        compared++;
        assert (changed === exp_chg) else begin
            mismatched++;
            $error("FAIL %s_changed: observed %b, expected %b", tag, changed, exp_chg);
        end
    endtask

    // Hold the given buttons for hold cycles, then release and let them settle.
    task automatic press(input logic nxt, input logic prv, input int hold);
        exp_t e;
        int   new_id;
        new_id = model_id;
        if (nxt && !prv) new_id = (model_id + 1) % NP;
        if (prv && !nxt) new_id = (model_id + NP - 1) % NP;
        if (hold >= DBC + 3 && new_id != model_id) begin
            e.cyc = cyc + DBC + 3;
            e.id  = 8'(new_id);
            sb.push_back(e);
            model_id = new_id;
        end
        btn_next = nxt;
        btn_prev = prv;
        idle(hold);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        idle(12);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        idle(n);
        model_id = 0;
        check_state("reset", 8'd0, 1'b0);
        rst = 1'b0;
        idle(12);
    endtask

    initial begin
        // Reset and let the stable levels settle low.
        idle(3);
        do_reset(3);

        // Held next: one step on edge 7, then nothing while still held.
        press(1'b1, 1'b0, 20);
        check_state("held_next", 8'd1, 1'b0);

        // Further next presses wrap, then prev from 0 wraps the other way.
        press(1'b1, 1'b0, 9);
        check_state("next_2", 8'd2, 1'b0);
        press(1'b1, 1'b0, 9);
        check_state("next_wrap", 8'd0, 1'b0);
        press(1'b0, 1'b1, 9);
        check_state("prev_wrap", 8'd2, 1'b0);
        press(1'b0, 1'b1, 9);
        check_state("prev_1", 8'd1, 1'b0);

        // Short glitch from a fresh reset: no press.
        do_reset(2);
        press(1'b1, 1'b0, 3);
        check_state("glitch", 8'd0, 1'b0);

        // Both buttons together cancel.
        press(1'b1, 1'b1, 15);
        check_state("both", 8'd0, 1'b0);

        // Prev held across reset release: nothing until re-pressed.
        rst = 1'b1;
        btn_prev = 1'b1;
        idle(3);
        model_id = 0;
        rst = 1'b0;
        idle(15);
        check_state("held_thru_rst", 8'd0, 1'b0);
        btn_prev = 1'b0;
        idle(12);
        press(1'b0, 1'b1, 9);
        check_state("prev_after_rst", 8'd2, 1'b0);

        // Reset mid-debounce discards the partial count.
        btn_next = 1'b1;
        idle(2);
        rst = 1'b1;
        model_id = 0;
        btn_next = 1'b0;
        idle(2);
        rst = 1'b0;
        idle(15);
        check_state("rst_mid_debounce", 8'd0, 1'b0);

        idle(2);
        compared++;
        assert (sb.size() == 0) else begin
            mismatched++;
            $error("FAIL pending_changes: observed %0d outstanding, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
